nes_pad_reader: RTL and testbench

// Serial NES-style gamepad reader: produces the per-player button levels (button_up/down/left/right, attack keys) consumed by the movement FSM.
// On each frame_rate tick: drives latch, clocks out 8 serial bits, decodes active-low data, publishes all buttons atomically.
// One instance per player; outputs held stable between polls.

---
 rtl/game_pkg.sv | 27 ++
 rtl/nes_pad_reader_sync_2ff.sv | 33 +++
 rtl/nes_pad_reader.sv | 193 +++++++++++++++++++
 tb/tb_nes_pad_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the per-player gamepad front end.
//   pad_state_t    : poll sequencer states of nes_pad_reader
//   PAD_BIT_*      : position of each button in the serial frame
//                    (first bit shifted out is A, last is Right)
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    PAD_IDLE,
    PAD_LATCH,
    PAD_LOW,
    PAD_HIGH,
    PAD_DONE
  } pad_state_t;

  localparam int PAD_BIT_A      = 0;
  localparam int PAD_BIT_B      = 1;
  localparam int PAD_BIT_SELECT = 2;
  localparam int PAD_BIT_START  = 3;
  localparam int PAD_BIT_UP     = 4;
  localparam int PAD_BIT_DOWN   = 5;
  localparam int PAD_BIT_LEFT   = 6;
  localparam int PAD_BIT_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Reset value is 1 so that an active-low pad line reads "released" until
// real data has propagated through.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   d_i      in  asynchronous input
//   q_o      out synchronized output
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// ---------------------------------------------------------------------------
// nes_pad_reader
// Serial NES-style gamepad reader, one instance per player. On a frame_rate
// request it strobes pad_latch, clocks the 8 serial bits out of the pad,
// decodes the active-low data and publishes all eight buttons in one cycle
// together with a buttons_valid pulse. Outputs hold between polls.
//   clk            in  system clock
//   reset_n        in  asynchronous active-low reset
//   frame_rate     in  one-cycle poll request (ignored while busy)
//   pad_data       in  serial pad data, asynchronous, 0 = pressed
//   pad_latch      out latch strobe to pad (registered)
//   pad_clk        out shift clock to pad (registered)
//   button_*       out pressed levels (1 = pressed)
//   buttons_valid  out one-cycle pulse when button_* were updated
//   busy           out poll in progress
// ---------------------------------------------------------------------------
module nes_pad_reader
  import game_pkg::*;
#(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter bit SOCD_NEUTRAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_rate,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic button_a,
  output logic button_b,
  output logic button_select,
  output logic button_start,
  output logic button_up,
  output logic button_down,
  output logic button_left,
  output logic button_right,
  output logic buttons_valid,
  output logic busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

  // Opposing directions cancel so the movement logic never sees both.
  function automatic logic [7:0] socd_resolve(input logic [7:0] raw);
    logic [7:0] res;
    res = raw;
    if (SOCD_NEUTRAL) begin
      if (raw[PAD_BIT_LEFT] && raw[PAD_BIT_RIGHT]) begin
        res[PAD_BIT_LEFT]  = 1'b0;
        res[PAD_BIT_RIGHT] = 1'b0;
      end
      if (raw[PAD_BIT_UP] && raw[PAD_BIT_DOWN]) begin
        res[PAD_BIT_UP]   = 1'b0;
        res[PAD_BIT_DOWN] = 1'b0;
      end
    end
    return res;
  endfunction

  logic pad_sync;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pad_data),
    .q_o     (pad_sync)
  );

  pad_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       btn_q, btn_d;
  logic             latch_q, latch_d;
  logic             pclk_q, pclk_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    latch_d = latch_q;
    pclk_d  = pclk_q;
    valid_d = 1'b0;

    case (state_q)
      PAD_IDLE: begin
        if (frame_rate) begin
          state_d = PAD_LATCH;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
          latch_d = 1'b1;
          pclk_d  = 1'b0;
        end
      end

      PAD_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = PAD_LOW;
          cnt_d   = '0;
          latch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Sample at the end of the low phase, when the pad output has had the
      // whole phase (minus synchronizer delay) to settle.
      PAD_LOW: begin
        if (cnt_q == HALF_LAST) begin
          shift_d[idx_q] = ~pad_sync;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = PAD_DONE;
          end else begin
            state_d = PAD_HIGH;
            pclk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PAD_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          state_d = PAD_LOW;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          pclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PAD_DONE: begin
        btn_d   = socd_resolve(shift_q);
        valid_d = 1'b1;
        state_d = PAD_IDLE;
      end

      default: begin
        state_d = PAD_IDLE;
        latch_d = 1'b0;
        pclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAD_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      btn_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      btn_q   <= btn_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      valid_q <= valid_d;
    end
  end

  assign pad_latch     = latch_q;
  assign pad_clk       = pclk_q;
  assign buttons_valid = valid_q;
  assign busy          = (state_q != PAD_IDLE);

  assign button_a      = btn_q[PAD_BIT_A];
  assign button_b      = btn_q[PAD_BIT_B];
  assign button_select = btn_q[PAD_BIT_SELECT];
  assign button_start  = btn_q[PAD_BIT_START];
  assign button_up     = btn_q[PAD_BIT_UP];
  assign button_down   = btn_q[PAD_BIT_DOWN];
  assign button_left   = btn_q[PAD_BIT_LEFT];
  assign button_right  = btn_q[PAD_BIT_RIGHT];

endmodule

// File: tb/tb_nes_pad_reader.sv
// ---------------------------------------------------------------------------
// tb_nes_pad_reader
// Bench for nes_pad_reader with LATCH_CYCLES=8, HALF_CYCLES=4. Two instances
// share one pad model: dut1 with SOCD_NEUTRAL=1, dut2 with SOCD_NEUTRAL=0
// (dut2 is only polled together with dut1, so both drive identical timing).
// Button vectors are {right,left,down,up,start,select,b,a}.
// ---------------------------------------------------------------------------
module tb_nes_pad_reader;

  typedef struct {
    logic [7:0] btn;
    int         due;
    int         latch_at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, frame_rate, frame_rate2, pad_data;
  logic pad_latch, pad_clk, valid, busy;
  logic pad_latch2, pad_clk2, valid2, busy2;
  logic a1, b1, se1, st1, u1, d1, l1, r1;
  logic a2, b2, se2, st2, u2, d2, l2, r2;
  logic [7:0] btn1, btn2;

  assign btn1 = {r1, l1, d1, u1, st1, se1, b1, a1};
  assign btn2 = {r2, l2, d2, u2, st2, se2, b2, a2};

  nes_pad_reader #(.LATCH_CYCLES(8), .HALF_CYCLES(4), .SOCD_NEUTRAL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_rate(frame_rate), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .button_a(a1), .button_b(b1), .button_select(se1), .button_start(st1),
    .button_up(u1), .button_down(d1), .button_left(l1), .button_right(r1),
    .buttons_valid(valid), .busy(busy)
  );

  nes_pad_reader #(.LATCH_CYCLES(8), .HALF_CYCLES(4), .SOCD_NEUTRAL(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .frame_rate(frame_rate2), .pad_data(pad_data),
    .pad_latch(pad_latch2), .pad_clk(pad_clk2),
    .button_a(a2), .button_b(b2), .button_select(se2), .button_start(st2),
    .button_up(u2), .button_down(d2), .button_left(l2), .button_right(r2),
    .buttons_valid(valid2), .busy(busy2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pad model: latch loads the pattern (bit 0 = A on the line), each pad_clk
  // rise advances one bit; line idles high once all bits are out.
  logic [7:0] pad_pattern = 8'hFF;
  bit         stuck       = 1'b0;
  int         release_at  = 0;
  int         rises       = 0;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) rises = 0;
    else           rises = rises + 1;
  end

  assign pad_data = (stuck || (release_at != 0 && rises >= release_at) || rises > 7)
                    ? 1'b1 : pad_pattern[rises[2:0]];

  exp_t q1[$];
  exp_t q2[$];

  // Monitor for dut1: pops an expectation per buttons_valid, checks timing
  // of the poll that produced it, and checks outputs hold otherwise.
  logic [7:0] hold1 = 8'h00;
  int   latch_rise = -1, latch_len = 0, pulses = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b0;
  exp_t e1;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold1 = 8'h00; latch_rise = -1; latch_len = 0; pulses = 0;
      prev_latch = 1'b0; prev_pclk = 1'b0;
    end else begin
      check("latch_clk_overlap", 32'(pad_latch & pad_clk), 32'd0);
      if (pad_latch && !prev_latch) latch_rise = cyc;
      if (pad_latch) latch_len++;
      if (pad_clk && !prev_pclk) pulses++;
      if (valid) begin
        if (q1.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("buttons", 32'(btn1), 32'(e1.btn));
          check("valid_cycle", 32'(cyc), 32'(e1.due));
          check("latch_start", 32'(latch_rise), 32'(e1.latch_at));
          check("latch_len", 32'(latch_len), 32'd8);
          check("pad_clk_pulses", 32'(pulses), 32'd7);
          hold1 = e1.btn;
        end
        latch_len = 0;
        pulses    = 0;
      end else begin
        check("hold", 32'(btn1), 32'(hold1));
      end
      prev_latch = pad_latch;
      prev_pclk  = pad_clk;
    end
  end

  logic [7:0] hold2 = 8'h00;
  exp_t e2;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold2 = 8'h00;
    end else begin
      check("latch_clk_overlap2", 32'(pad_latch2 & pad_clk2), 32'd0);
      if (valid2) begin
        if (q2.size() == 0) begin
          check("unexpected_valid2", 32'd1, 32'd0);
        end else begin
          e2 = q2.pop_front();
          check("buttons2", 32'(btn2), 32'(e2.btn));
          check("valid_cycle2", 32'(cyc), 32'(e2.due));
          hold2 = e2.btn;
        end
      end else begin
        check("hold2", 32'(btn2), 32'(hold2));
      end
    end
  end

  // Request at the negedge where cyc==k; edge N=k+1 sees it, outputs at N+69.
  task automatic poll(input logic [7:0] pat, input logic [7:0] x1,
                      input bit both, input logic [7:0] x2);
    @(negedge clk);
    pad_pattern = pat;
    frame_rate  = 1'b1;
    frame_rate2 = both;
    q1.push_back('{btn: x1, due: cyc + 70, latch_at: cyc + 1});
    if (both) q2.push_back('{btn: x2, due: cyc + 70, latch_at: cyc + 1});
    @(negedge clk);
    frame_rate  = 1'b0;
    frame_rate2 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q1.size() + q2.size()), 32'd0);
    q1.delete();
    q2.delete();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; frame_rate = 1'b0; frame_rate2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_buttons", 32'(btn1), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_pclk", 32'(pad_clk), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // A and Up pressed
    poll(8'hEE, 8'h11, 1'b0, 8'h00);
    drain(200);
    // A, Left, Right pressed: neutralised on dut1, raw on dut2
    poll(8'h3E, 8'h01, 1'b1, 8'hC1);
    drain(200);
    // Up and Down pressed
    poll(8'hCF, 8'h00, 1'b1, 8'h30);
    drain(200);

    // Second request 20 cycles after the first is dropped
    poll(8'h7F, 8'h80, 1'b0, 8'h00);
    repeat (19) @(negedge clk);
    check("busy_on_second_req", 32'(busy), 32'd1);
    frame_rate = 1'b1;
    @(negedge clk);
    frame_rate = 1'b0;
    drain(200);
    repeat (120) @(negedge clk);

    // All pressed, pad releases everything after bit 3 was sampled
    release_at = 4;
    poll(8'h00, 8'h0F, 1'b0, 8'h00);
    drain(200);
    release_at = 0;

    // Disconnected pad, three polls
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      poll(8'h00, 8'h00, 1'b0, 8'h00);
      drain(200);
    end
    stuck = 1'b0;

    // Reset in the middle of a poll
    poll(8'hEE, 8'h11, 1'b0, 8'h00);
    drain(200);
    @(negedge clk);
    pad_pattern = 8'h00;
    frame_rate  = 1'b1;
    @(negedge clk);
    frame_rate  = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_buttons", 32'(btn1), 32'd0);
    check("midrst_buttons2", 32'(btn2), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_latch", 32'(pad_latch), 32'd0);
    check("midrst_pclk", 32'(pad_clk), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_latch", 32'(pad_latch), 32'd0);

    poll(8'hEE, 8'h11, 1'b0, 8'h00);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
